// File: rtl/noc_inject_arbiter.sv
// rtl/noc_inject_arbiter.sv - packet-level round-robin arbiter feeding the router injection FIFO
// Wormhole-locked HEAD..TAIL grant; labels live in the top bits of each flit.
module noc_inject_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int FLIT_TOTAL_SIZE = 34,
  localparam int FLIT_DATA_SIZE = 32
) (
  input  logic                             clk_router,
  input  logic                             rst_router_n,
  input  logic [N_REQ-1:0]                 req_rempty,
  input  logic [N_REQ*FLIT_TOTAL_SIZE-1:0] req_rdata,
  output logic [N_REQ-1:0]                 req_ren,
  input  logic [N_REQ-1:0]                 req_en,
  input  logic                             inj_full,
  input  logic                             inj_afull,
  output logic                             inj_wen,
  output logic [FLIT_TOTAL_SIZE-1:0]       inj_wdata,
  output logic                             grant_vld,
  output logic [IDW-1:0]                   grant_id,
  output logic                             err_proto,
  input  logic                             err_clr,
  output logic [15:0]                      pkt_cnt
);

  localparam int LBL_W = FLIT_TOTAL_SIZE - FLIT_DATA_SIZE;
  localparam logic [LBL_W-1:0] LBL_BODY     = 2'b00;
  localparam logic [LBL_W-1:0] LBL_TAIL     = 2'b01;
  localparam logic [LBL_W-1:0] LBL_HEAD     = 2'b10;
  localparam logic [LBL_W-1:0] LBL_HEADTAIL = 2'b11;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [IDW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]             grant_id_q, grant_id_d;
  logic                       inj_wen_q, inj_wen_d;
  logic [FLIT_TOTAL_SIZE-1:0] inj_wdata_q, inj_wdata_d;
  logic                       err_proto_q, err_proto_d;
  logic [15:0]                pkt_cnt_q, pkt_cnt_d;

  logic                       stall;
  logic [N_REQ-1:0]           cand;
  logic                       win_vld;
  logic [IDW-1:0]             win_id;
  logic [IDW-1:0]             sel_id;
  logic [FLIT_TOTAL_SIZE-1:0] sel_flit;
  logic [LBL_W-1:0]           sel_lbl;
  logic [N_REQ-1:0]           ren_c;
  logic                       err_set;
  logic                       pkt_done;

  // Explicit compare keeps the wrap correct when N_REQ is not a power of two.
  function automatic logic [IDW-1:0] ptr_next(input logic [IDW-1:0] p);
    if (int'(p) >= N_REQ - 1) return '0;
    return p + 1'b1;
  endfunction

  assign stall = inj_full | inj_afull;
  assign cand  = ~req_rempty & req_en;

  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_vld && cand[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  assign sel_id   = (state_q == LOCKED) ? grant_id_q : win_id;
  assign sel_flit = req_rdata[int'(sel_id)*FLIT_TOTAL_SIZE +: FLIT_TOTAL_SIZE];
  assign sel_lbl  = sel_flit[FLIT_TOTAL_SIZE-1:FLIT_DATA_SIZE];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    inj_wen_d   = 1'b0;
    inj_wdata_d = '0;
    err_set     = 1'b0;
    pkt_done    = 1'b0;
    ren_c       = '0;
    if (state_q == IDLE) begin
      if (win_vld && !stall) begin
        ren_c[win_id] = 1'b1;
        case (sel_lbl)
          LBL_HEAD: begin
            inj_wen_d   = 1'b1;
            inj_wdata_d = sel_flit;
            state_d     = LOCKED;
            grant_id_d  = win_id;
          end
          LBL_HEADTAIL: begin
            inj_wen_d   = 1'b1;
            inj_wdata_d = sel_flit;
            rr_ptr_d    = ptr_next(win_id);
            pkt_done    = 1'b1;
          end
          default: begin
            // Orphan BODY/TAIL is drained so it cannot block the requester forever.
            err_set  = 1'b1;
            rr_ptr_d = ptr_next(win_id);
          end
        endcase
      end
    end else begin
      if (!req_rempty[grant_id_q] && !stall) begin
        ren_c[grant_id_q] = 1'b1;
        inj_wen_d         = 1'b1;
        inj_wdata_d       = sel_flit;
        case (sel_lbl)
          LBL_TAIL: begin
            state_d  = IDLE;
            rr_ptr_d = ptr_next(grant_id_q);
            pkt_done = 1'b1;
          end
          LBL_BODY: ;
          default: err_set = 1'b1;
        endcase
      end
    end
    err_proto_d = err_set | (err_proto_q & ~err_clr);
    pkt_cnt_d   = pkt_cnt_q + {15'd0, pkt_done};
  end

  always_ff @(posedge clk_router or negedge rst_router_n) begin
    if (!rst_router_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      inj_wen_q   <= 1'b0;
      inj_wdata_q <= '0;
      err_proto_q <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      inj_wen_q   <= inj_wen_d;
      inj_wdata_q <= inj_wdata_d;
      err_proto_q <= err_proto_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign req_ren   = ren_c & {N_REQ{rst_router_n}};
  assign inj_wen   = inj_wen_q;
  assign inj_wdata = inj_wdata_q;
  assign grant_vld = (state_q == LOCKED);
  assign grant_id  = grant_id_q;
  assign err_proto = err_proto_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb/tb_noc_inject_arbiter.sv - directed and random bench for noc_inject_arbiter
// Requester FIFOs are modelled as queues; a packet-level model predicts every cycle.
module tb_noc_inject_arbiter;

  localparam int N  = 4;
  localparam int FT = 34;
  localparam int FD = 32;
  localparam logic [1:0] L_BODY = 2'b00;
  localparam logic [1:0] L_TAIL = 2'b01;
  localparam logic [1:0] L_HEAD = 2'b10;
  localparam logic [1:0] L_HT   = 2'b11;

  logic            clk_router = 1'b0;
  logic            rst_router_n;
  logic [N-1:0]    req_rempty;
  logic [N*FT-1:0] req_rdata;
  logic [N-1:0]    req_ren;
  logic [N-1:0]    req_en;
  logic            inj_full;
  logic            inj_afull;
  logic            inj_wen;
  logic [FT-1:0]   inj_wdata;
  logic            grant_vld;
  logic [1:0]      grant_id;
  logic            err_proto;
  logic            err_clr;
  logic [15:0]     pkt_cnt;

  always #5 clk_router = ~clk_router;

  noc_inject_arbiter #(.N_REQ(N)) dut (
    .clk_router  (clk_router),
    .rst_router_n(rst_router_n),
    .req_rempty  (req_rempty),
    .req_rdata   (req_rdata),
    .req_ren     (req_ren),
    .req_en      (req_en),
    .inj_full    (inj_full),
    .inj_afull   (inj_afull),
    .inj_wen     (inj_wen),
    .inj_wdata   (inj_wdata),
    .grant_vld   (grant_vld),
    .grant_id    (grant_id),
    .err_proto   (err_proto),
    .err_clr     (err_clr),
    .pkt_cnt     (pkt_cnt)
  );

  logic [FT-1:0] rq [N][$];

  bit            m_locked;
  int            m_owner;
  int            m_ptr;
  bit            m_err;
  int            m_cnt;
  bit            m_wen;
  logic [FT-1:0] m_wdata;

  int tests = 0;
  int fails = 0;
  int dut_wen_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FT-1:0] mk(input logic [1:0] lb, input logic [31:0] d);
    return {lb, d};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_rempty[i] = (rq[i].size() == 0);
      req_rdata[i*FT +: FT] = (rq[i].size() != 0) ? rq[i][0] : '0;
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_err = 0; m_cnt = 0;
    m_wen = 0; m_wdata = '0;
    for (int i = 0; i < N; i++) rq[i].delete();
  endtask

  // Closest eligible requester at or after the pointer, measured as circular distance.
  function automatic int pick();
    int best, bd, d;
    if (inj_full || inj_afull) return -1;
    if (m_locked) return (rq[m_owner].size() != 0) ? m_owner : -1;
    best = -1; bd = N;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() != 0 && req_en[i]) begin
        d = (i - m_ptr + N) % N;
        if (d < bd) begin bd = d; best = i; end
      end
    end
    return best;
  endfunction

  task automatic cycle();
    int            pop_id;
    logic [N-1:0]  er;
    logic [FT-1:0] f;
    logic [1:0]    lb;
    bit            set, clr_s;
    drive();
    @(negedge clk_router);
    pop_id = pick();
    er = '0;
    if (pop_id >= 0) er[pop_id] = 1'b1;
    chk("req_ren", 64'(req_ren), 64'(er));
    clr_s = err_clr;
    @(posedge clk_router);
    #1;
    m_wen = 0; m_wdata = '0; set = 0;
    if (pop_id >= 0) begin
      f  = rq[pop_id].pop_front();
      lb = f[FT-1:FD];
      if (!m_locked) begin
        if (lb == L_HEAD) begin
          m_wen = 1; m_wdata = f; m_locked = 1; m_owner = pop_id;
        end else begin
          m_ptr = (pop_id + 1) % N;
          if (lb == L_HT) begin
            m_wen = 1; m_wdata = f; m_cnt = (m_cnt + 1) % 65536;
          end else set = 1;
        end
      end else begin
        m_wen = 1; m_wdata = f;
        if (lb == L_TAIL) begin
          m_locked = 0; m_ptr = (m_owner + 1) % N; m_cnt = (m_cnt + 1) % 65536;
        end else if (lb != L_BODY) set = 1;
      end
    end
    if (set) m_err = 1;
    else if (clr_s) m_err = 0;
    if (inj_wen === 1'b1) dut_wen_cnt++;
    chk("inj_wen", 64'(inj_wen), 64'(m_wen));
    chk("inj_wdata", 64'(inj_wdata), 64'(m_wdata));
    chk("grant_vld", 64'(grant_vld), 64'(m_locked));
    if (m_locked) chk("grant_id", 64'(grant_id), 64'(m_owner));
    chk("err_proto", 64'(err_proto), 64'(m_err));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
    drive();
  endtask

  task automatic push_pkt(input int i, input int len);
    if (len <= 1) rq[i].push_back(mk(L_HT, $urandom));
    else begin
      rq[i].push_back(mk(L_HEAD, $urandom));
      for (int k = 0; k < len - 2; k++) rq[i].push_back(mk(L_BODY, $urandom));
      rq[i].push_back(mk(L_TAIL, $urandom));
    end
  endtask

  initial begin
    rst_router_n = 0; req_en = '1; inj_full = 0; inj_afull = 0; err_clr = 0;
    model_reset();
    drive();
    repeat (3) @(posedge clk_router);
    #1;
    chk("rst_wen", 64'(inj_wen), 64'(0));
    chk("rst_wdata", 64'(inj_wdata), 64'(0));
    chk("rst_cnt", 64'(pkt_cnt), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    rst_router_n = 1;
    repeat (10) cycle();

    // Reset while locked must drop the grant immediately.
    rq[0].push_back(mk(L_HEAD, 32'h5)); rq[0].push_back(mk(L_BODY, 32'h6));
    cycle();
    chk("pre_rst_lock", 64'(grant_vld), 64'(1));
    #2 rst_router_n = 0;
    #1;
    chk("async_rst_gvld", 64'(grant_vld), 64'(0));
    chk("rst_ren", 64'(req_ren), 64'(0));
    model_reset();
    drive();
    repeat (2) @(posedge clk_router);
    #1 rst_router_n = 1;

    // Round robin over three single-flit packets.
    rq[0].push_back(mk(L_HT, 32'h11));
    rq[1].push_back(mk(L_HT, 32'h22));
    rq[2].push_back(mk(L_HT, 32'h33));
    repeat (4) cycle();
    chk("rr_pkt_cnt", 64'(pkt_cnt), 64'(3));

    // Wormhole lock holds through an empty gap.
    rq[0].push_back(mk(L_HEAD, 32'hA0)); rq[0].push_back(mk(L_BODY, 32'hA1));
    rq[1].push_back(mk(L_HT, 32'hB0));
    repeat (2) cycle();
    repeat (3) begin
      cycle();
      chk("lock_no_ren1", 64'(req_ren[1]), 64'(0));
    end
    rq[0].push_back(mk(L_TAIL, 32'hA2));
    repeat (3) cycle();
    chk("lock_pkt_cnt", 64'(pkt_cnt), 64'(5));

    // Backpressure mid-packet.
    dut_wen_cnt = 0;
    for (int k = 0; k < 4; k++)
      rq[2].push_back(mk((k == 0) ? L_HEAD : (k == 3) ? L_TAIL : L_BODY, 32'hC0 + k));
    repeat (2) cycle();
    inj_afull = 1;
    repeat (5) cycle();
    inj_afull = 0;
    repeat (3) cycle();
    chk("bp_writes", 64'(dut_wen_cnt), 64'(4));
    chk("bp_pkt_cnt", 64'(pkt_cnt), 64'(6));

    // Protocol errors and clear priority.
    rq[2].push_back(mk(L_BODY, 32'hD0));
    cycle();
    chk("orphan_err", 64'(err_proto), 64'(1));
    err_clr = 1; cycle(); err_clr = 0;
    chk("err_cleared", 64'(err_proto), 64'(0));
    rq[3].push_back(mk(L_HEAD, 32'hE0));
    cycle();
    rq[3].push_back(mk(L_HEAD, 32'hE1));
    err_clr = 1; cycle(); err_clr = 0;
    chk("set_beats_clr", 64'(err_proto), 64'(1));
    rq[3].push_back(mk(L_TAIL, 32'hE2));
    cycle();
    err_clr = 1; cycle(); err_clr = 0;
    chk("err_pkt_cnt", 64'(pkt_cnt), 64'(7));

    // Enable mask only takes effect at packet boundaries.
    rq[1].push_back(mk(L_HEAD, 32'hF0)); rq[1].push_back(mk(L_BODY, 32'hF1));
    rq[1].push_back(mk(L_TAIL, 32'hF2)); rq[1].push_back(mk(L_HT, 32'hF3));
    cycle();
    req_en[1] = 0;
    rq[2].push_back(mk(L_HT, 32'hF4));
    rq[0].push_back(mk(L_HT, 32'hF5));
    repeat (6) cycle();
    chk("en_skip_q1", 64'(rq[1].size()), 64'(1));
    chk("en_q0_served", 64'(rq[0].size()), 64'(0));
    chk("en_q2_served", 64'(rq[2].size()), 64'(0));
    req_en[1] = 1;
    repeat (2) cycle();
    chk("en_restored", 64'(rq[1].size()), 64'(0));
    chk("en_pkt_cnt", 64'(pkt_cnt), 64'(11));

    // Random traffic with stalls, mask changes, stray labels and clears.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() < 6 && $urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 15) == 0)
            rq[i].push_back(mk(2'($urandom_range(0, 3)), $urandom));
          else
            push_pkt(i, $urandom_range(1, 4));
        end
      end
      inj_afull = ($urandom_range(0, 3) == 0);
      inj_full  = ($urandom_range(0, 7) == 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) req_en = 4'($urandom);
      cycle();
    end
    inj_afull = 0; inj_full = 0; err_clr = 0; req_en = '1;
    repeat (40) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
